// File: rtl/i2c_target.sv
// I2C target with 7-bit address (ADDR), oversampled on clk; open-drain SDA via sda_oe.
// Define I2C_GENERAL_CALL_EN to also ACK the general-call address byte 8'h00.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_next,
    output logic       busy,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] k_idle     = 4'd0;
    localparam logic [3:0] k_addr     = 4'd1;
    localparam logic [3:0] k_addr_ack = 4'd2;
    localparam logic [3:0] k_rx       = 4'd3;
    localparam logic [3:0] k_rx_ack   = 4'd4;
    localparam logic [3:0] k_tx       = 4'd5;
    localparam logic [3:0] k_tx_ack   = 4'd6;
    localparam logic [3:0] k_wait     = 4'd7;

    logic [3:0] state;
    logic [2:0] bit_ctr;
    logic       byte_full;
    logic [7:0] shift_reg;
    logic       rw;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Synchronizers idle at 1 so reset release on a quiet bus decodes no edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, scl_stable_hi, start_cond, stop_cond, addr_hit, gen_call;

    assign scl_rise      = scl_s2 & ~scl_h;
    assign scl_fall      = ~scl_s2 & scl_h;
    // SCL must be high in both samples, so a simultaneous SCL/SDA change is only an SCL edge.
    assign scl_stable_hi = scl_s2 & scl_h;
    assign start_cond    = scl_stable_hi & sda_h & ~sda_s2;
    assign stop_cond     = scl_stable_hi & ~sda_h & sda_s2;
    assign addr_hit      = (shift_reg[7:1] == ADDR);
`ifdef I2C_GENERAL_CALL_EN
    assign gen_call      = (shift_reg == 8'h00);
`else
    assign gen_call      = 1'b0;
`endif
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= k_idle;
            bit_ctr   <= 3'd0;
            byte_full <= 1'b0;
            shift_reg <= 8'h00;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_next   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_next  <= 1'b0;
            if (stop_cond) begin
                state     <= k_idle;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_ctr   <= 3'd0;
                byte_full <= 1'b0;
            end else if (start_cond) begin
                state     <= k_addr;
                sda_oe    <= 1'b0;
                bit_ctr   <= 3'd0;
                byte_full <= 1'b0;
            end else begin
                case (state)
                    k_addr, k_rx: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_ctr   <= bit_ctr + 3'd1;
                            if (bit_ctr == 3'd7) byte_full <= 1'b1;
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            if (state == k_addr) begin
                                if (addr_hit || gen_call) begin
                                    sda_oe <= 1'b1;
                                    rw     <= shift_reg[0];
                                    busy   <= 1'b1;
                                    state  <= k_addr_ack;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= k_wait;
                                end
                            end else begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                                sda_oe   <= 1'b1;
                                state    <= k_rx_ack;
                            end
                        end
                    end
                    k_addr_ack: begin
                        if (scl_fall) begin
                            if (!rw) begin
                                sda_oe <= 1'b0;
                                state  <= k_rx;
                            end else begin
                                tx_next   <= 1'b1;
                                shift_reg <= tx_data;
                                sda_oe    <= ~tx_data[7];
                                bit_ctr   <= 3'd0;
                                state     <= k_tx;
                            end
                        end
                    end
                    k_rx_ack: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= k_rx;
                        end
                    end
                    k_tx: begin
                        if (scl_rise) begin
                            bit_ctr <= bit_ctr + 3'd1;
                            if (bit_ctr == 3'd7) byte_full <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_full) begin
                                byte_full <= 1'b0;
                                sda_oe    <= 1'b0;
                                state     <= k_tx_ack;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                sda_oe    <= ~shift_reg[6];
                            end
                        end
                    end
                    k_tx_ack: begin
                        // Controller NACK ends the read; ACK fetches the next byte.
                        if (scl_rise && sda_s2) begin
                            state <= k_wait;
                        end else if (scl_fall) begin
                            tx_next   <= 1'b1;
                            shift_reg <= tx_data;
                            sda_oe    <= ~tx_data[7];
                            bit_ctr   <= 3'd0;
                            state     <= k_tx;
                        end
                    end
                    k_idle, k_wait: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= k_idle;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller tasks, write-vector table, rx scoreboard,
// and hand sequences for read, repeated START and mid-transfer reset.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int T = 8;
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_TX   = 4'd5;
    localparam logic [3:0] S_WAIT = 4'd7;
`ifdef I2C_GENERAL_CALL_EN
    localparam logic GC_ACK = 1'b1;
`else
    localparam logic GC_ACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_next;
    logic       busy;
    logic [3:0] dbg_state;

    assign sda_in = sda_drv & ~sda_oe;

    i2c_target #(.ADDR(7'h50)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_next(tx_next), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int oe_cnt = 0;
    int both_cnt = 0;
    int rd_idx = 0;
    logic [7:0] rx_log [256];
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (rx_valid && rx_cnt < 256) begin
            rx_log[rx_cnt[7:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_next) tx_cnt <= tx_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (rx_valid && tx_next) both_cnt <= both_cnt + 1;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; clk_wait(T);
        scl_in = 1'b1;  clk_wait(T);
        sda_drv = 1'b0; clk_wait(T);
        scl_in = 1'b0;  clk_wait(2);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; clk_wait(T);
        scl_in = 1'b1;  clk_wait(T);
        sda_drv = 1'b1; clk_wait(T);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;   clk_wait(T);
        scl_in = 1'b1; clk_wait(T);
        scl_in = 1'b0; clk_wait(2);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; clk_wait(T);
        scl_in = 1'b1;  clk_wait(T / 2);
        b = sda_in;     clk_wait(T / 2);
        scl_in = 1'b0;  clk_wait(2);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v = {v[6:0], b};
        end
    endtask

    task automatic drain();
        check("rx_count", rx_cnt - rd_idx, exp_q.size());
        while (rd_idx < rx_cnt && exp_q.size() > 0) begin
            check("rx_data", {24'h0, rx_log[rd_idx[7:0]]}, {24'h0, exp_q.pop_front()});
            rd_idx++;
        end
        rd_idx = rx_cnt;
        exp_q.delete();
    endtask

    task automatic do_write(input logic [7:0] addr_byte, input logic [7:0] data, input logic exp_ack);
        logic a;
        int oe0;
        oe0 = oe_cnt;
        bus_start();
        send_byte(addr_byte);
        read_bit(a);
        check("addr_ack", a, !exp_ack);
        check("busy_after_addr", busy, exp_ack);
        if (exp_ack) exp_q.push_back(data);
        send_byte(data);
        read_bit(a);
        check("data_ack", a, !exp_ack);
        bus_stop();
        check("busy_after_stop", busy, 0);
        check("idle_after_stop", dbg_state, S_IDLE);
        check("oe_seen", oe_cnt != oe0, exp_ack);
        drain();
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       exp_ack;
    } wr_vec_t;

    wr_vec_t vecs [6];

    initial begin
        logic a;
        logic [7:0] v;
        int tx0;

        vecs[0] = '{8'hA0, 8'hA5, 1'b1};
        vecs[1] = '{8'hA2, 8'h3C, 1'b0};
        vecs[2] = '{8'hA0, 8'h00, 1'b1};
        vecs[3] = '{8'hA0, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 8'h12, GC_ACK};
        vecs[5] = '{8'hA0, 8'($urandom_range(0, 255)), 1'b1};

        clk_wait(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_next", tx_next, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        clk_wait(4);

        for (int i = 0; i < 6; i++) do_write(vecs[i].addr_byte, vecs[i].data, vecs[i].exp_ack);
        check("rx_data_reg", rx_data, vecs[5].data);

        // Read two bytes, controller ACKs the first and NACKs the second.
        tx0 = tx_cnt;
        tx_data = 8'h3C;
        bus_start();
        send_byte(8'hA1);
        read_bit(a);
        check("rd_addr_ack", a, 0);
        check("rd_busy", busy, 1);
        read_byte(v);
        check("rd_byte0", v, 8'h3C);
        tx_data = 8'hC3;
        send_bit(1'b0);
        read_byte(v);
        check("rd_byte1", v, 8'hC3);
        send_bit(1'b1);
        clk_wait(4);
        check("rd_release", sda_oe, 0);
        check("rd_wait_state", dbg_state, S_WAIT);
        check("rd_tx_pulses", tx_cnt - tx0, 2);
        bus_stop();
        check("rd_busy_stop", busy, 0);
        drain();

        // Partial write byte abandoned by a repeated START into a read.
        tx0 = tx_cnt;
        tx_data = 8'h5A;
        bus_start();
        send_byte(8'hA0);
        read_bit(a);
        check("rs_addr0_ack", a, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_start();
        send_byte(8'hA1);
        read_bit(a);
        check("rs_addr1_ack", a, 0);
        read_byte(v);
        check("rs_byte", v, 8'h5A);
        send_bit(1'b1);
        bus_stop();
        check("rs_tx_pulses", tx_cnt - tx0, 1);
        drain();

        // Reset while the target is driving a transmitted bit.
        tx_data = 8'h00;
        bus_start();
        send_byte(8'hA1);
        read_bit(a);
        check("rst_tx_addr_ack", a, 0);
        read_bit(a); read_bit(a); read_bit(a);
        clk_wait(2);
        check("pre_rst_oe", sda_oe, 1);
        check("pre_rst_state", dbg_state, S_TX);
        rst_n = 1'b0;
        #1;
        check("rst_oe_async", sda_oe, 0);
        check("rst_state_idle", dbg_state, S_IDLE);
        check("rst_busy_clr", busy, 0);
        clk_wait(2);
        rst_n = 1'b1;
        clk_wait(2);
        do_write(8'hA0, 8'h77, 1'b1);

        check("no_rx_tx_overlap", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) with a 7-bit address, the bus-side counterpart to the team's I2C controller. Oversamples SCL/SDA on the system clock, detects START/STOP, matches the address and ACKs it, then either receives bytes from the controller or transmits bytes supplied by the host logic. Open-drain SDA is driven through an output-enable; SCL is input only.

## Interface

- `ADDR`, 7'h50: target address, compared against address-byte bits [7:1].

- `clk`  in  1  system clock; must run at least 8x the SCL rate.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  raw SCL pin level, asynchronous.
- `sda_in`  in  1  raw SDA pin level, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `rx_data`  out  8  last byte received from the controller.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new.
- `tx_data`  in  8  byte to send on a read; sampled when `tx_next` is high.
- `tx_next`  out  1  one-cycle pulse; `tx_data` captured this cycle.
- `busy`  out  1  high from address match until STOP, or until a START that is not followed by a match.

## Operation

- SCL and SDA each pass through a 2-flop synchronizer plus one history flop. Edges and conditions are decoded from the synchronized and history values.
- Conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - A START in any state clears the bit counter, releases SDA and enters `k_addr`. This covers repeated START.
  - A STOP in any state releases SDA and enters `k_idle`.
- Data bits are sampled on SCL rising edges, MSB first. `sda_oe` changes only on SCL falling edges.
- States are 4-bit `localparam`s. `bit_ctr` is 3 bits and wraps 7->0.
  - `k_idle`: wait for START.
  - `k_addr`: shift 8 bits. On the falling edge after bit 8:
    - address match -> assert `sda_oe`, latch R/W, go to `k_addr_ack`, set `busy`.
    - mismatch -> go to `k_wait`.
  - `k_addr_ack`: on the next falling edge:
    - R/W=0 -> release SDA, go to `k_rx`.
    - R/W=1 -> pulse `tx_next`, load `tx_data` into the shift register, drive `sda_oe = ~bit7`, go to `k_tx`.
  - `k_rx`: shift 8 bits. On the falling edge after bit 8:
    - update `rx_data` and pulse `rx_valid` in the same cycle.
    - assert `sda_oe` (ACK) and go to `k_rx_ack`.
  - `k_rx_ack`: on the falling edge, release SDA and go to `k_rx`.
  - `k_tx`: on each falling edge, present the next bit (`sda_oe = ~bit`). On the falling edge after bit 8, release SDA and go to `k_tx_ack`.
  - `k_tx_ack`: sample SDA on the rising edge.
    - 0 (ACK) -> on the next falling edge, pulse `tx_next`, load, drive bit7, go to `k_tx`.
    - 1 (NACK) -> go to `k_wait`.
  - `k_wait`: SDA released and bits ignored; only START or STOP exits.
- A START or STOP seen mid-byte discards the partial byte. `rx_valid` does not pulse for it.

## Timing

- Reset values: state `k_idle`; `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_next`=0, `busy`=0. Synchronizer flops reset to 1 (idle bus).
- Pin-to-decision latency: an edge on `scl_in`/`sda_in` is acted on 3 `clk` cycles later. `sda_oe` updates in that same cycle.
- `rx_valid` and `tx_next` are exactly one cycle wide and never high together.
- If SCL and SDA change in the same `clk` cycle, the change is treated as an SCL edge only; no START/STOP is decoded.
- Asserting `rst_n` mid-transfer releases SDA immediately. Release is asynchronous.

## Configuration

- `I2C_GENERAL_CALL_EN` defined: address byte 8'h00 (general call, write) is also ACKed and proceeds into `k_rx` exactly like an address match.
- Not defined: 8'h00 is treated as a mismatch (NACK, `k_wait`).

## Test plan

- Write to 0x50, data 0xA5, STOP:
  - `sda_oe` high during both ACK bits.
  - one `rx_valid` pulse with `rx_data`=8'hA5.
  - `busy` falls at STOP.
- Write to 0x51:
  - `sda_oe` stays 0 throughout, `busy` stays 0, no `rx_valid`.
- Read from 0x50 with `tx_data`=8'h3C, controller ACKs, then `tx_data`=8'hC3, controller NACKs:
  - SDA carries 0x3C then 0xC3.
  - exactly two `tx_next` pulses.
  - SDA released after the NACK.
- Write 0x50 with 4 data bits, then repeated START and read 0x50:
  - no `rx_valid` pulse.
  - address re-ACKed and `tx_next` pulses.
- Address 0x00 write with data 0x12:
  - with `I2C_GENERAL_CALL_EN`: ACK, `rx_data`=8'h12.
  - without: NACK, no `rx_valid`.
- `rst_n` low during bit 3 of a transmitted byte:
  - `sda_oe`=0 asynchronously.
  - state `k_idle`.
  - next START/address 0x50 ACKed normally.
